// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start/data/stop recovery from a 16x tick, valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_deframer #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 rx_clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rx_serial,
    output logic                 baud_gen_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam logic [3:0] LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic [3:0]           tcnt;
    logic [3:0]           bcnt;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    assign baud_gen_en = (state != IDLE);
    assign rx_busy     = (state != IDLE);

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0 & PARITY_ODD;
`endif

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_serial;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (!rx_s)
                        state <= START;
                end
                START: if (rx_tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == 4'd7) begin
                        tcnt  <= '0;
                        bcnt  <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: if (rx_tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        bcnt  <= bcnt + 4'd1;
                        if (bcnt == LAST) begin
                            tcnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (rx_tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        par_bad <= ((^shreg) ^ rx_s) != PARITY_ODD;
                        tcnt    <= '0;
                        state   <= STOP;
                    end
                end
`endif
                STOP: if (rx_tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        tcnt  <= '0;
                        state <= rx_s ? IDLE : BRK;
                        // a word still waiting for the host wins over the new one
                        if (rx_valid && !rx_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            rx_data   <= shreg;
                            frame_err <= !rx_s;
                            rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                        end
                    end
                end
                BRK: begin
                    tcnt <= '0;
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: 4-clock ticks, 64 clocks per bit.
// Parity vectors run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_deframer;

    logic       rx_clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_tick;
    logic       rx_serial = 1'b1;
    logic       rx_ready = 1'b1;
    logic       baud_gen_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       rx_busy;

    logic [1:0] tdiv = 2'd0;
    int         checks = 0;
    int         failures = 0;
    int         acc = 0;
    int         ovr = 0;
    int         a0;
    int         o0;
    logic [7:0] cap_d = 8'h00;
    logic       cap_fe = 1'b0;
    logic       cap_pe = 1'b0;

    uart_rx_deframer dut (
        .rx_clk      (rx_clk),
        .rst         (rst),
        .rx_tick     (rx_tick),
        .rx_serial   (rx_serial),
        .baud_gen_en (baud_gen_en),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .rx_busy     (rx_busy)
    );

    always #5 rx_clk = ~rx_clk;

    always @(posedge rx_clk) tdiv <= tdiv + 2'd1;
    assign rx_tick = (tdiv == 2'd3);

    always @(negedge rx_clk) begin
        if (rx_valid && rx_ready) begin
            acc++;
            cap_d  = rx_data;
            cap_fe = frame_err;
            cap_pe = parity_err;
        end
        if (overrun)
            ovr++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge rx_clk);
    endtask

    task automatic bit_out(input logic b);
        rx_serial = b;
        wait_clk(64);
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++)
            bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_out(p);
`else
        if (p) rx_serial = 1'b1;
`endif
        bit_out(stop);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_en"},    32'(baud_gen_en), 32'd0);
        check({tag, "_data"},  32'(rx_data),     32'd0);
        check({tag, "_valid"}, 32'(rx_valid),    32'd0);
        check({tag, "_fe"},    32'(frame_err),   32'd0);
        check({tag, "_pe"},    32'(parity_err),  32'd0);
        check({tag, "_ovr"},   32'(overrun),     32'd0);
        check({tag, "_busy"},  32'(rx_busy),     32'd0);
    endtask

    initial begin
        wait_clk(3);
        check_reset_vals("rst_in");
        rst = 1'b0;
        wait_clk(2);
        check_reset_vals("rst_out");

        // clean 0xA5
        a0 = acc;
        send(8'hA5, 1'b0, 1'b1);
        wait_clk(32);
        check("a5_cnt",  acc - a0,      32'd1);
        check("a5_data", 32'(cap_d),    32'hA5);
        check("a5_fe",   32'(cap_fe),   32'd0);
        check("a5_pe",   32'(cap_pe),   32'd0);
        check("a5_busy", 32'(rx_busy),  32'd0);

        // false start: 5 ticks low
        a0 = acc;
        rx_serial = 1'b0;
        wait_clk(20);
        check("fs_busy1", 32'(rx_busy), 32'd1);
        rx_serial = 1'b1;
        wait_clk(60);
        check("fs_busy0", 32'(rx_busy),     32'd0);
        check("fs_en0",   32'(baud_gen_en), 32'd0);
        check("fs_cnt",   acc - a0,         32'd0);

        // framing error followed by a long break
        a0 = acc;
        send(8'h3C, 1'b0, 1'b0);
        wait_clk(160);
        check("brk_busy", 32'(rx_busy), 32'd1);
        check("brk_cnt",  acc - a0,     32'd1);
        check("brk_data", 32'(cap_d),   32'h3C);
        check("brk_fe",   32'(cap_fe),  32'd1);
        rx_serial = 1'b1;
        wait_clk(10);
        check("brk_idle", 32'(rx_busy), 32'd0);
        check("brk_cnt2", acc - a0,     32'd1);

        // back-to-back frames with host stalled
        rx_ready = 1'b0;
        o0 = ovr;
        wait_clk(8);
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        wait_clk(32);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data",  32'(rx_data),  32'h11);
        check("ovr_cnt",   ovr - o0,      32'd1);
        rx_ready = 1'b1;
        wait_clk(2);
        check("ovr_clr",  32'(rx_valid), 32'd0);
        check("ovr_acc",  32'(cap_d),    32'h11);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b0, 1'b1);
        wait_clk(32);
        check("par_bad_d", 32'(cap_d),  32'h07);
        check("par_bad",   32'(cap_pe), 32'd1);
        send(8'h07, 1'b1, 1'b1);
        wait_clk(32);
        check("par_ok",    32'(cap_pe), 32'd0);
`endif

        // reset in the middle of the 4th data bit of 0xC3
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b1);
        bit_out(1'b0);
        rx_serial = 1'b0;
        wait_clk(32);
        check("mid_busy", 32'(rx_busy), 32'd1);
        o0 = ovr;
        rst = 1'b1;
        wait_clk(1);
        check_reset_vals("mid_rst");
        rst = 1'b0;
        rx_serial = 1'b1;
        wait_clk(128);
        a0 = acc;
        send(8'h5A, 1'b0, 1'b1);
        wait_clk(32);
        check("post_cnt",  acc - a0,    32'd1);
        check("post_data", 32'(cap_d),  32'h5A);
        check("post_fe",   32'(cap_fe), 32'd0);
        check("post_ovr",  ovr - o0,    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

UART receive deframer: consumes the 16x oversample `rx_tick` from the receiver baud generator and recovers bytes from the asynchronous serial line. It owns the generator's `baud_gen_en`, validates start and stop bits, and holds each received word in an output register with a valid/ready handshake toward the host logic.

## Interface
- `DATA_BITS`, 8, data bits per frame (5–9), LSB first
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd
- `rx_clk`  input  1  system clock, same clock as the baud generator
- `rst`  input  1  asynchronous, active-high reset
- `rx_tick`  input  1  one-cycle pulse at 16x baud, from the generator
- `rx_serial`  input  1  raw serial line, asynchronous, idle high
- `baud_gen_en`  output  1  enables the baud generator; high whenever state ≠ IDLE
- `rx_data`  output  DATA_BITS  last received word
- `rx_valid`  output  1  `rx_data` and error flags are valid
- `rx_ready`  input  1  consumer accepts the word when high with `rx_valid`
- `frame_err`  output  1  stop bit sampled low; qualified by `rx_valid`
- `parity_err`  output  1  parity mismatch; qualified by `rx_valid`; constant 0 without the macro
- `overrun`  output  1  one-cycle pulse when a completed frame is dropped
- `rx_busy`  output  1  state ≠ IDLE

## Operation
- `rx_serial` passes through a 2-flop synchronizer (both flops reset to 1). All logic uses the synchronized value `rx_s`.
- 4-bit tick counter `tcnt` increments on `rx_tick` and is cleared on every state entry.
- States:
  - **IDLE**: `rx_s`=0 → START.
  - **START**: on the 8th tick (`tcnt`=7), sample `rx_s`. 0 → DATA. 1 → IDLE (false start, no output).
  - **DATA**: on every 16th tick (`tcnt`=15), shift `rx_s` into a shift register, LSB first. After `DATA_BITS` samples → PARITY if compiled in, else STOP.
  - **PARITY**: on the 16th tick, sample the parity bit and compute the mismatch → STOP.
  - **STOP**: on the 16th tick, sample the stop bit, then deliver the word.
    - `rx_s`=1 → IDLE.
    - `rx_s`=0 → BRK, with `frame_err`=1 on the delivered word.
  - **BRK**: wait for `rx_s`=1 → IDLE. Prevents re-triggering during a break.
- Deliver:
  - If `rx_valid`=1 and `rx_ready`=0: assert `overrun` for one cycle and keep the old word and flags.
  - Otherwise: load `rx_data`, `frame_err` and `parity_err`, and set `rx_valid`=1.
- Handshake:
  - `rx_valid` clears on the cycle after `rx_valid`&`rx_ready`.
  - If a deliver coincides with the accept, the new word loads and `rx_valid` stays 1; this is not an overrun.
- Returning to IDLE at mid-stop-bit allows back-to-back frames without a gap.

## Timing
- Reset values: `baud_gen_en`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `rx_busy`=0; state IDLE; synchronizer = 1.
- Line-to-detect latency is 2 clocks (synchronizer) plus 1 clock to enter START.
- The generator counter is not cleared by `baud_gen_en`, so start-bit sampling jitter is up to one tick period (1/16 bit). This is accepted.
- Word and flags appear 1 clock after the `rx_tick` that samples the stop bit.
- `rx_tick` arriving while in IDLE or BRK is ignored.
- Reset asserted mid-frame returns to IDLE immediately. Any pending word is discarded and no `overrun` is reported.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present.
  - Frame is start + `DATA_BITS` + parity + stop.
  - `parity_err`=1 when the XOR of the data bits and the parity bit ≠ `PARITY_ODD`.
- `UART_RX_PARITY_EN` undefined:
  - PARITY state and its logic are absent.
  - `parity_err` is tied to 0.

## Test plan
- 0xA5 frame with a stop bit, ticks every 4 clocks, `rx_ready`=1 → one `rx_valid` pulse with `rx_data`=0xA5, `frame_err`=0, `parity_err`=0.
- Line low for 5 ticks, then high → return to IDLE, `baud_gen_en` drops, no `rx_valid`.
- 0x3C with stop bit = 0 and line held low for 40 ticks → `rx_data`=0x3C with `frame_err`=1. `rx_busy` stays 1 until the line rises, with no second frame.
- 0x11 then 0x22 back-to-back with `rx_ready`=0 → `rx_data` stays 0x11 and `overrun` pulses once. Raise `rx_ready` → `rx_valid` clears.
- With `UART_RX_PARITY_EN`, `PARITY_ODD`=0: 0x07 with parity bit 0 → `parity_err`=1; 0x07 with parity bit 1 → `parity_err`=0.
- Assert `rst` during the 4th data bit → all outputs at reset values next cycle. A following clean 0x5A frame is received correctly.
